// File: rtl/aes_round_key_buffer.sv
// ---------------------------------------------------------------------------
// aes_round_key_buffer
//   Collects the byte-serial round-key stream from the key-expansion unit,
//   packs it into 128-bit round keys, stores rounds 0..NUM_ROUNDS and replays
//   them to the round datapath forward (encrypt) or reverse (decrypt) over a
//   valid/ready handshake.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_round_key_buffer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_BYTES  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                kb_valid,
  input  logic [7:0]                          kb_data,
  output logic                                keys_ready,
  input  logic                                start,
  input  logic                                decrypt,
  output logic                                rk_valid,
  input  logic                                rk_ready,
  output logic [KEY_BYTES*8-1:0]              rk_data,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]     rk_round,
  output logic                                rk_last,
  output logic                                ovf_err
);

  localparam int KW = KEY_BYTES * 8;
  localparam int RW = $clog2(NUM_ROUNDS + 1);
  localparam int BW = $clog2(KEY_BYTES);
  localparam logic [RW-1:0] LAST_RND  = RW'(NUM_ROUNDS);
  localparam logic [BW-1:0] LAST_BYTE = BW'(KEY_BYTES - 1);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t           state_q;
  logic [BW-1:0]    byte_cnt_q;
  logic [RW-1:0]    wr_round_q;
  logic [KW-9:0]    pack_q;        // holds the first KEY_BYTES-1 bytes of a key
  logic [KW-1:0]    mem_q [0:NUM_ROUNDS];
  logic             dir_q;
  logic [RW-1:0]    rd_round_q;
  logic             keys_ready_q;
  logic             rk_valid_q;
  logic [KW-1:0]    rk_data_q;
  logic [RW-1:0]    rk_round_q;
  logic             rk_last_q;
  logic             ovf_err_q;

  logic             kb_accept;
  logic             word_done;
  logic [KW-1:0]    word_full;
  logic             start_go;
  logic             accept;
  logic             dir_d;
  logic [RW-1:0]    rd_round_d;
  logic             last_d;
  logic [KW-1:0]    rd_key;

  // Byte acceptance, next read pointer and the key it selects. The output
  // registers load from the *next* pointer so a new key appears one cycle
  // after start or after a handshake, giving one key per cycle.
  always_comb begin
    kb_accept  = (state_q == ST_FILL) && kb_valid && !flush;
    word_done  = kb_accept && (byte_cnt_q == LAST_BYTE);
    word_full  = {pack_q, kb_data};
    start_go   = (state_q == ST_IDLE) && start;
    accept     = (state_q == ST_SERVE) && rk_valid_q && rk_ready;
    dir_d      = start_go ? decrypt : dir_q;
    rd_round_d = rd_round_q;
    if (start_go) begin
      rd_round_d = decrypt ? LAST_RND : '0;
    end else if (accept && !rk_last_q) begin
      rd_round_d = dir_q ? (rd_round_q - 1'b1) : (rd_round_q + 1'b1);
    end
    last_d = dir_d ? (rd_round_d == '0) : (rd_round_d == LAST_RND);
    rd_key = mem_q[rd_round_d];
  end

  // Key storage: written once per completed key, contents need no reset.
  always_ff @(posedge clk) begin
    if (word_done) begin
      mem_q[wr_round_q] <= word_full;
    end
  end

  // Control FSM with registered outputs; flush outranks every other input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      byte_cnt_q   <= '0;
      wr_round_q   <= '0;
      pack_q       <= '0;
      dir_q        <= 1'b0;
      rd_round_q   <= '0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_data_q    <= '0;
      rk_round_q   <= '0;
      rk_last_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_FILL;
      byte_cnt_q   <= '0;
      wr_round_q   <= '0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_last_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (kb_valid) begin
            pack_q <= {pack_q[KW-17:0], kb_data};
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              wr_round_q <= wr_round_q + 1'b1;
              if (wr_round_q == LAST_RND) begin
                state_q      <= ST_IDLE;
                keys_ready_q <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        ST_IDLE: begin
          if (kb_valid) begin
            ovf_err_q <= 1'b1;
          end
          if (start) begin
            dir_q      <= dir_d;
            rd_round_q <= rd_round_d;
            rk_valid_q <= 1'b1;
            rk_data_q  <= rd_key;
            rk_round_q <= rd_round_d;
            rk_last_q  <= last_d;
            state_q    <= ST_SERVE;
          end
        end

        ST_SERVE: begin
          if (kb_valid) begin
            ovf_err_q <= 1'b1;
          end
          if (accept) begin
            if (rk_last_q) begin
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              rd_round_q <= rd_round_d;
              rk_data_q  <= rd_key;
              rk_round_q <= rd_round_d;
              rk_last_q  <= last_d;
            end
          end
        end

        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign keys_ready = keys_ready_q;
  assign rk_valid   = rk_valid_q;
  assign rk_data    = rk_data_q;
  assign rk_round   = rk_round_q;
  assign rk_last    = rk_last_q;
  assign ovf_err    = ovf_err_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_key_buffer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_key_buffer
//   Directed bench for the round-key buffer using the FIPS-197 expanded key
//   for 2b7e151628aed2a6abf7158809cf4f3c plus a synthetic second key set.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_key_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         kb_valid;
  logic [7:0]   kb_data;
  logic         keys_ready;
  logic         start;
  logic         decrypt;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         ovf_err;

  int checks   = 0;
  int failures = 0;

  logic [127:0] fips [0:10];
  logic [127:0] alt  [0:10];
  logic [127:0] cur  [0:10];

  aes_round_key_buffer #(.NUM_ROUNDS(10), .KEY_BYTES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .keys_ready (keys_ready),
    .start      (start),
    .decrypt    (decrypt),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_round   (rk_round),
    .rk_last    (rk_last),
    .ovf_err    (ovf_err)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic use_keys(input bit sel_alt);
    for (int r = 0; r <= 10; r++) cur[r] = sel_alt ? alt[r] : fips[r];
  endtask

  // Stream 176 bytes, optionally with random gaps during which start is pulsed.
  task automatic fill(input bit gaps);
    for (int r = 0; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (gaps) begin
          while ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            kb_valid = 1'b0;
            start    = 1'b1;
            chk("fill_start_ignored", {127'd0, rk_valid}, 128'd0);
          end
        end
        @(negedge clk);
        if (r == 10 && i == 15) chk("keys_ready_before_last", {127'd0, keys_ready}, 128'd0);
        start    = 1'b0;
        kb_valid = 1'b1;
        kb_data  = cur[r][127-8*i -: 8];
      end
    end
    @(negedge clk);
    kb_valid = 1'b0;
    chk("keys_ready_after_last", {127'd0, keys_ready}, 128'd1);
    chk("fill_no_ovf", {127'd0, ovf_err}, 128'd0);
  endtask

  // One replay pass; pat[cyc%4] drives rk_ready, exp_cycles is hand-derived.
  task automatic replay(input bit dec, input logic [3:0] pat, input int exp_cycles);
    int er;
    int endr;
    int cyc;
    bit done;
    @(negedge clk);
    start    = 1'b1;
    decrypt  = dec;
    rk_ready = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    decrypt = 1'b0;
    er   = dec ? 10 : 0;
    endr = dec ? 0 : 10;
    done = 1'b0;
    for (cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      chk("rk_valid", {127'd0, rk_valid}, 128'd1);
      chk("rk_round", {124'd0, rk_round}, 128'(er));
      chk("rk_data", rk_data, cur[er]);
      chk("rk_last", {127'd0, rk_last}, {127'd0, (er == endr)});
      rk_ready = pat[cyc % 4];
      if (rk_ready) begin
        if (er == endr) done = 1'b1;
        else er = dec ? er - 1 : er + 1;
      end
    end
    @(negedge clk);
    rk_ready = 1'b0;
    chk("pass_done", {127'd0, done}, 128'd1);
    chk("pass_cycles", 128'(cyc), 128'(exp_cycles));
    chk("valid_after_last", {127'd0, rk_valid}, 128'd0);
    chk("keys_ready_kept", {127'd0, keys_ready}, 128'd1);
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int r = 0; r <= 10; r++)
      for (int i = 0; i < 16; i++)
        alt[r][127-8*i -: 8] = 8'((r * 16 + i) * 7 + 3);

    rst = 1'b1; flush = 1'b0; kb_valid = 1'b0; kb_data = 8'h00;
    start = 1'b0; decrypt = 1'b0; rk_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_rk_last", {127'd0, rk_last}, 128'd0);
    chk("rst_ovf_err", {127'd0, ovf_err}, 128'd0);
    chk("rst_rk_data", rk_data, 128'd0);
    chk("rst_rk_round", {124'd0, rk_round}, 128'd0);
    rst = 1'b0;

    // Contiguous FIPS fill, forward, reverse, and stalled forward passes
    use_keys(1'b0);
    fill(1'b0);
    replay(1'b0, 4'b1111, 11);
    replay(1'b1, 4'b1111, 11);
    replay(1'b0, 4'b1001, 21);

    // Gappy refill with start pulses mid-fill
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_keys_ready", {127'd0, keys_ready}, 128'd0);
    fill(1'b1);
    replay(1'b0, 4'b1111, 11);
    replay(1'b1, 4'b1001, 21);

    // Byte pushed while full: sticky overflow
    @(negedge clk); kb_valid = 1'b1; kb_data = 8'hff;
    @(negedge clk); kb_valid = 1'b0;
    chk("ovf_set", {127'd0, ovf_err}, 128'd1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", {127'd0, ovf_err}, 128'd1);
    chk("ovf_keys_ready", {127'd0, keys_ready}, 128'd1);

    // Flush with a simultaneous byte (dropped), then refill with new keys
    @(negedge clk); flush = 1'b1; kb_valid = 1'b1; kb_data = 8'h00;
    @(negedge clk); flush = 1'b0; kb_valid = 1'b0;
    chk("flush_ovf_clr", {127'd0, ovf_err}, 128'd0);
    chk("flush_keys_clr", {127'd0, keys_ready}, 128'd0);
    chk("flush_rk_valid", {127'd0, rk_valid}, 128'd0);
    use_keys(1'b1);
    fill(1'b0);
    replay(1'b0, 4'b1111, 11);
    replay(1'b1, 4'b1001, 21);

    // Async reset in the middle of a forward pass
    @(negedge clk); start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && rk_round != 4'd5; k++) @(negedge clk);
    chk("pre_rst_round", {124'd0, rk_round}, 128'd5);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", {127'd0, rk_valid}, 128'd0);
    chk("rst_mid_keys_ready", {127'd0, keys_ready}, 128'd0);
    @(negedge clk); rst = 1'b0; rk_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = 1'b1;
      chk("post_rst_start_ignored", {127'd0, rk_valid}, 128'd0);
    end
    @(negedge clk); start = 1'b0;
    chk("post_rst_not_ready", {127'd0, keys_ready}, 128'd0);
    use_keys(1'b0);
    fill(1'b0);
    replay(1'b0, 4'b1111, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
